// File: rtl/adder_l1_engine.sv
// Streaming L1-distance engine: accumulates sum(|if - w|) over NDATA elements,
// LANES pairs per beat, and presents the (optionally negated) total with a valid/ready handshake.
module adder_l1_engine #(
  parameter  int NBIT  = 16,
  parameter  int LANES = 8,
  parameter  int NDATA = 64,
  localparam int BEATS = NDATA / LANES,
  localparam int RW    = NBIT + $clog2(NDATA) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [NBIT*LANES-1:0] i_if,
  input  logic [NBIT*LANES-1:0] i_w,
  input  logic                  i_signed,
  input  logic                  i_neg,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [RW-1:0]         o_result
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t          state_q,  state_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic [RW-1:0]   acc_q,    acc_d;
  logic            signed_q, signed_d;
  logic            neg_q,    neg_d;
  logic            valid_q,  valid_d;
  logic [RW-1:0]   result_q, result_d;

  logic            mode_signed;
  logic            mode_neg;
  logic [NBIT-1:0] lane_if;
  logic [NBIT-1:0] lane_w;
  logic [NBIT:0]   lane_a;
  logic [NBIT:0]   lane_b;
  logic [NBIT:0]   lane_d;
  logic [NBIT:0]   lane_abs;
  logic [RW-1:0]   beat_sum;
  logic [RW-1:0]   acc_next;
  logic            accept;
  logic            last_beat;

  // The first beat of a vector is processed with the live mode inputs, since
  // the latched copies only become valid on the edge that accepts it.
  always_comb begin
    mode_signed = (state_q == ST_IDLE) ? i_signed : signed_q;
    mode_neg    = (state_q == ST_IDLE) ? i_neg    : neg_q;
    lane_if     = '0;
    lane_w      = '0;
    lane_a      = '0;
    lane_b      = '0;
    lane_d      = '0;
    lane_abs    = '0;
    beat_sum    = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_if  = i_if[k*NBIT +: NBIT];
      lane_w   = i_w[k*NBIT +: NBIT];
      lane_a   = {mode_signed & lane_if[NBIT-1], lane_if};
      lane_b   = {mode_signed & lane_w[NBIT-1],  lane_w};
      lane_d   = lane_a - lane_b;
      lane_abs = lane_d[NBIT] ? -lane_d : lane_d;
      beat_sum = beat_sum + {{(RW-NBIT){1'b0}}, lane_abs[NBIT-1:0]};
    end
  end

  always_comb begin
    accept    = i_valid && (state_q != ST_OUT);
    acc_next  = (state_q == ST_IDLE) ? beat_sum : (acc_q + beat_sum);
    last_beat = ((state_q == ST_IDLE) && (BEATS == 1)) ||
                ((state_q == ST_ACC) && (cnt_q == CW'(BEATS - 1)));

    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    signed_d = signed_q;
    neg_d    = neg_q;
    valid_d  = valid_q;
    result_d = result_q;

    if (state_q == ST_OUT) begin
      if (i_ready) begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    end else if (accept) begin
      acc_d = acc_next;
      if (state_q == ST_IDLE) begin
        signed_d = i_signed;
        neg_d    = i_neg;
      end
      if (last_beat) begin
        state_d  = ST_OUT;
        cnt_d    = '0;
        valid_d  = 1'b1;
        result_d = mode_neg ? -acc_next : acc_next;
      end else begin
        state_d = ST_ACC;
        cnt_d   = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      signed_q <= 1'b0;
      neg_q    <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      signed_q <= signed_d;
      neg_q    <= neg_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign o_ready  = !RST && (state_q != ST_OUT);
  assign o_valid  = valid_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_adder_l1_engine.sv
// Scoreboard bench for adder_l1_engine: stimulus pushes expected results,
// a negedge monitor pops and compares whenever o_valid rises.
module tb_adder_l1_engine;

  localparam int NBIT  = 16;
  localparam int LANES = 8;
  localparam int NDATA = 64;
  localparam int BEATS = NDATA / LANES;
  localparam int RW    = 23;
  localparam int VW    = NBIT * LANES;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_signed = 1'b0;
  logic          i_neg = 1'b0;
  logic          i_ready = 1'b1;
  logic [VW-1:0] i_if = '0;
  logic [VW-1:0] i_w = '0;
  logic          o_ready;
  logic          o_valid;
  logic [RW-1:0] o_result;

  int errors = 0;
  int checks = 0;
  int stall_req = 0;
  logic [RW-1:0] exp_q[$];
  logic [VW-1:0] vi[BEATS];
  logic [VW-1:0] vw[BEATS];

  always #5 CLK = ~CLK;

  adder_l1_engine #(.NBIT(NBIT), .LANES(LANES), .NDATA(NDATA)) dut (
    .CLK(CLK), .RST(RST), .i_valid(i_valid), .o_ready(o_ready),
    .i_if(i_if), .i_w(i_w), .i_signed(i_signed), .i_neg(i_neg),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
    checks++;
    if (act !== exv) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exv, exv);
    end
  endtask

  task automatic clear_vec();
    for (int b = 0; b < BEATS; b++) begin
      vi[b] = '0;
      vw[b] = '0;
    end
  endtask

  task automatic send_beat(input logic [VW-1:0] ifv, input logic [VW-1:0] wv,
                           input logic s, input logic n);
    int t;
    t = 0;
    @(negedge CLK);
    i_if = ifv; i_w = wv; i_signed = s; i_neg = n; i_valid = 1'b1;
    while (!o_ready && t < 200) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 200) chk("beat_accept_timeout", 32'd0, 32'd1);
    @(posedge CLK);
    #1 i_valid = 1'b0;
  endtask

  // Later beats drive inverted modes; the engine must keep the first-beat values.
  task automatic send_vec(input logic s, input logic n, input int gap, input logic [RW-1:0] expv);
    exp_q.push_back(expv);
    for (int b = 0; b < BEATS; b++) begin
      send_beat(vi[b], vw[b], (b == 0) ? s : !s, (b == 0) ? n : !n);
      if (gap > 0 && b != BEATS - 1) begin
        i_if = '1; i_w = '0;
        repeat (gap) @(posedge CLK);
      end
    end
  endtask

  // Downstream ready: holds i_ready low for stall_req cycles of each result.
  initial begin
    int sc;
    sc = 0;
    forever begin
      @(posedge CLK);
      #2;
      if (o_valid) begin
        if (sc < stall_req) begin
          i_ready = 1'b0;
          sc++;
        end else i_ready = 1'b1;
      end else begin
        sc = 0;
        i_ready = 1'b1;
      end
    end
  end

  initial begin
    logic prev;
    logic [RW-1:0] held;
    logic [RW-1:0] e;
    prev = 1'b0;
    held = '0;
    forever begin
      @(negedge CLK);
      if (RST) prev = 1'b0;
      else begin
        if (o_valid) begin
          chk("ready_low_in_out", 32'(o_ready), 32'd0);
          if (!prev) begin
            if (exp_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
            else begin
              e = exp_q.pop_front();
              chk("result", 32'(o_result), 32'(e));
            end
            held = o_result;
          end else chk("result_hold", 32'(o_result), 32'(held));
        end
        prev = o_valid;
      end
    end
  end

  initial begin
    int t;
    int sample_if[LANES] = '{4, 7, 2, 1, 7, 12, 1, 8};
    int sample_w[LANES]  = '{5, 1, 3, 0, 5, 1, 3, 0};

    repeat (2) @(posedge CLK);
    #1;
    chk("reset_ready", 32'(o_ready), 32'd0);
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_result", 32'(o_result), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1 chk("ready_after_reset", 32'(o_ready), 32'd1);

    clear_vec();
    for (int k = 0; k < LANES; k++) begin
      vi[0][k*NBIT +: NBIT] = 16'(sample_if[k]);
      vw[0][k*NBIT +: NBIT] = 16'(sample_w[k]);
    end
    send_vec(1'b0, 1'b0, 0, 23'd32);
    send_vec(1'b0, 1'b1, 0, 23'h7FFFE0);

    clear_vec();
    vi[0][15:0] = 16'hFFFD;
    vw[0][15:0] = 16'h0005;
    send_vec(1'b1, 1'b0, 0, 23'd8);
    send_vec(1'b0, 1'b0, 0, 23'd65528);

    clear_vec();
    vi[0][15:0] = 16'h8000;
    vw[0][15:0] = 16'h7FFF;
    send_vec(1'b1, 1'b0, 0, 23'd65535);
    send_vec(1'b0, 1'b1, 0, 23'h7FFFFF);

    for (int b = 0; b < BEATS; b++) begin
      vi[b] = '1;
      vw[b] = '0;
    end
    send_vec(1'b0, 1'b0, 0, 23'd4194240);

    clear_vec();
    for (int k = 0; k < LANES; k++) begin
      vi[0][k*NBIT +: NBIT] = 16'(sample_if[k]);
      vw[0][k*NBIT +: NBIT] = 16'(sample_w[k]);
    end
    vi[BEATS-1][15:0] = 16'd100;
    stall_req = 5;
    send_vec(1'b0, 1'b0, 1, 23'd132);
    send_vec(1'b0, 1'b1, 1, 23'h7FFF7C);
    stall_req = 0;

    for (int b = 0; b < 4; b++) send_beat('1, '0, 1'b0, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("mid_reset_ready", 32'(o_ready), 32'd0);
    chk("mid_reset_valid", 32'(o_valid), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1 chk("ready_after_mid_reset", 32'(o_ready), 32'd1);
    clear_vec();
    for (int k = 0; k < LANES; k++) begin
      vi[0][k*NBIT +: NBIT] = 16'(sample_if[k]);
      vw[0][k*NBIT +: NBIT] = 16'(sample_w[k]);
    end
    send_vec(1'b0, 1'b0, 0, 23'd32);

    t = 0;
    while ((exp_q.size() != 0 || o_valid) && t < 200) begin
      @(posedge CLK);
      t++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_l1_engine.md
ADDER_L1_ENGINE -- requirements
Module: adder_l1_engine

Interface
REQ-001 Parameter NBIT, default 16, element width in bits.
REQ-002 Parameter LANES, default 8, element pairs accepted per beat.
REQ-003 Parameter NDATA, default 64, elements per vector. It SHALL be a positive multiple of LANES; BEATS = NDATA/LANES.
REQ-004 Derived width RW = NBIT + clog2(NDATA) + 1 (23 at defaults).
REQ-005 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 RST  input  1  reset, synchronous, active-high.
REQ-007 i_valid  input  1  input beat valid.
REQ-008 o_ready  output  1  engine can accept an input beat.
REQ-009 i_if  input  NBIT*LANES  input-feature lanes; lane k occupies bits [k*NBIT +: NBIT].
REQ-010 i_w  input  NBIT*LANES  weight lanes, same packing as i_if.
REQ-011 i_signed  input  1  1 = lanes are two's complement; 0 = lanes are unsigned.
REQ-012 i_neg  input  1  1 = output the negated distance, -sum (AdderNet similarity).
REQ-013 o_valid  output  1  result valid.
REQ-014 i_ready  input  1  downstream accepts the result.
REQ-015 o_result  output  RW  signed L1 distance or its negation.

Function
REQ-016 A beat SHALL be accepted on a rising edge when i_valid && o_ready.
REQ-017 FSM states: IDLE (beat count 0), ACC (1..BEATS-1 beats taken), OUT (result held).
REQ-018 o_ready SHALL be 1 in IDLE and ACC and 0 in OUT.
REQ-019 On the first beat of a vector (accepted in IDLE), i_signed and i_neg SHALL be latched. Values on later beats of the same vector SHALL be ignored.
REQ-020 Per lane, the engine SHALL form |if - w| using an NBIT+1-bit difference, interpreted per the latched mode. The magnitude SHALL fit in NBIT unsigned bits.
REQ-021 Each accepted beat SHALL add the sum of all LANES magnitudes into an RW-bit accumulator. The first beat SHALL overwrite the accumulator rather than add to it.
REQ-022 Overflow SHALL NOT occur. No saturation logic SHALL be built; RW covers the worst case of NDATA*(2^NBIT-1).
REQ-023 When beat BEATS is accepted, the FSM SHALL enter OUT on that edge. o_valid SHALL go high in the next cycle, giving a latency of 1 cycle after the last beat.
REQ-024 In OUT, o_result SHALL equal the accumulator if the latched i_neg is 0, or its two's-complement negation if it is 1.
REQ-025 While o_valid && !i_ready, o_result and o_valid SHALL hold stable.
REQ-026 On an edge with o_valid && i_ready, the FSM SHALL return to IDLE and clear o_valid. No input beat SHALL be accepted on that same edge, because o_ready is 0 in OUT.
REQ-027 If BEATS == 1, IDLE SHALL go directly to OUT and ACC SHALL be unused.
REQ-028 The beat counter SHALL wrap to 0 on entering OUT. Gaps with i_valid low SHALL stall without changing state.
REQ-029 Inputs are ignored whenever they are not accepted.

Reset
REQ-030 When RST is high at an edge, the engine SHALL enter IDLE and set to 0: the beat counter, the accumulator, the latched modes, o_valid and o_result.
REQ-031 While RST is high, o_ready SHALL be 0. It SHALL be 1 in the first cycle after RST is deasserted.
REQ-032 RST asserted mid-vector or in OUT SHALL discard the partial or pending result. No o_valid pulse SHALL follow.

Verification
REQ-033 Basic sum (defaults, unsigned, neg=0). Stimulus: beat0 if={4,7,2,1,7,12,1,8}, w={5,1,3,0,5,1,3,0}; beats 1-7 all zero. Response: o_result=32, o_valid high 1 cycle after beat 7.
REQ-034 Negate. Same vectors with i_neg=1 on beat0 (i_neg=0 on later beats). Response: o_result=-32 (0x7FFFE0); the later-beat i_neg value is ignored.
REQ-035 Signed vs unsigned. Lane0 if=0xFFFD, w=0x0005, all else 0. Response: signed gives 8; unsigned gives 65528.
REQ-036 Worst case. Unsigned, all if=0xFFFF, w=0. Response: o_result=4194240, no wrap.
REQ-037 Backpressure and gaps. i_valid toggles every other cycle, and i_ready is held low 5 cycles after o_valid. Response: result is correct, o_result/o_valid are stable while stalled, o_ready=0 in OUT, and the next vector is accepted only after the handshake edge.
REQ-038 Reset mid-op. RST is pulsed after beat 3, then a full new vector is sent. Response: no o_valid before the new vector completes, and the result reflects only the new vector.
